// File: rtl/iencoder_loader.sv
// Instruction encoder/loader: turns field tuples into 32-bit RV32I words and
// writes them to sequential instruction-memory addresses until halt or full.
module iencoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [20:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] K_LOAD   = 3'b000;
  localparam logic [2:0] K_ITYPE  = 3'b001;
  localparam logic [2:0] K_RTYPE  = 3'b011;
  localparam logic [2:0] K_STORE  = 3'b010;
  localparam logic [2:0] K_BRANCH = 3'b110;
  localparam logic [2:0] K_JAL    = 3'b111;
  localparam logic [2:0] K_JALR   = 3'b101;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              w_is_halt;
  logic              w_imm12_ok;
  logic              w_imm13_ok;
  logic              w_imm_err;
  logic [31:0]       w_word;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_full;
  logic              r_err;

  assign w_ready   = (r_state == ST_RUN) && !start;
  assign w_accept  = in_valid && w_ready;
  assign w_is_halt = (kind == 3'b100);

  // Sign-extension checks: every bit above the field's sign bit must match it.
  assign w_imm12_ok = (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
  assign w_imm13_ok = ((imm[20:12] == 9'h000) || (imm[20:12] == 9'h1FF)) && !imm[0];

  // Field packing per kind; halt (and anything unmatched) yields the halt word.
  always_comb begin
    w_word    = 32'h0000_007F;
    w_imm_err = 1'b0;
    case (kind)
      K_LOAD: begin
        w_word    = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        w_imm_err = !w_imm12_ok;
      end
      K_ITYPE: begin
        w_word    = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        w_imm_err = !w_imm12_ok;
      end
      K_JALR: begin
        w_word    = {imm[11:0], rs1, funct3, rd, 7'b1100111};
        w_imm_err = !w_imm12_ok;
      end
      K_RTYPE: begin
        w_word    = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      end
      K_STORE: begin
        w_word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        w_imm_err = !w_imm12_ok;
      end
      K_BRANCH: begin
        w_word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        w_imm_err = !w_imm13_ok;
      end
      K_JAL: begin
        w_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        w_imm_err = imm[0];
      end
      default: begin
        w_word    = 32'h0000_007F;
        w_imm_err = 1'b0;
      end
    endcase
  end

  // Next state and address counter; start restarts from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (start) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      if (w_is_halt) begin
        w_state_nxt = ST_DONE;
      end else if (r_cnt == LAST_ADDR) begin
        w_state_nxt = ST_FULL;
      end else begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write port and status flags, all landing in the cycle after the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_addr  <= r_cnt;
        r_wdata <= w_word;
      end
      r_done <= (w_state_nxt == ST_DONE);
      r_full <= (w_state_nxt == ST_FULL);
      if (start) begin
        r_err <= 1'b0;
      end else if (w_accept && w_imm_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign full       = r_full;
  assign err        = r_err;

endmodule

// File: tb/tb_iencoder_loader.sv
// Bench for iencoder_loader: a 256-word and a 4-word instance share stimulus
// and are compared every cycle against a tuple-level reference model.
module tb_iencoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [20:0] imm;

  logic        b_ready, b_we, b_done, b_full, b_err;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        s_ready, s_we, s_done, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iencoder_loader #(.ADDR_W(8)) u_big (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .done(b_done), .full(b_full), .err(b_err)
  );

  iencoder_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .done(s_done), .full(s_full), .err(s_err)
  );

  // Reference model state, index 0 = 256-word instance, 1 = 4-word instance.
  int          depth [2] = '{256, 4};
  bit          m_run [2];
  bit          m_done[2];
  bit          m_full[2];
  bit          m_err [2];
  bit          m_we  [2];
  bit          m_show[2];
  int          m_cnt [2];
  int          e_addr[2];
  logic [31:0] e_wdata[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [2:0] k, input logic [20:0] im);
    logic [31:0] x;
    logic [31:0] regs;
    x    = 32'($signed(im));
    regs = (32'(rs1) << 15) | (32'(funct3) << 12);
    case (k)
      3'b000: return ((x & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'h03;
      3'b001: return ((x & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'h13;
      3'b101: return ((x & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'h67;
      3'b011: return (32'(funct7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
      3'b010: return (((x >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                     | ((x & 32'h1F) << 7) | 32'h23;
      3'b110: return (((x >> 12) & 32'h1) << 31) | (((x >> 5) & 32'h3F) << 25)
                     | (32'(rs2) << 20) | regs | (((x >> 1) & 32'hF) << 8)
                     | (((x >> 11) & 32'h1) << 7) | 32'h63;
      3'b111: return (((x >> 20) & 32'h1) << 31) | (((x >> 1) & 32'h3FF) << 21)
                     | (((x >> 11) & 32'h1) << 20) | (((x >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'h6F;
      default: return 32'h0000_007F;
    endcase
  endfunction

  function automatic bit ref_err(input logic [2:0] k, input logic [20:0] im);
    int v;
    v = $signed(im);
    case (k)
      3'b000, 3'b001, 3'b101, 3'b010: return (v < -2048) || (v > 2047);
      3'b110: return (v < -4096) || (v > 4094) || (im[0] == 1'b1);
      3'b111: return im[0] == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit acc;
    for (int i = 0; i < 2; i++) begin
      m_show[i] = 1'b0;
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_full[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
        m_we[i] = 0; m_show[i] = 1'b1; e_addr[i] = 0; e_wdata[i] = 32'h0;
      end else begin
        acc = m_run[i] && !start && in_valid;
        m_we[i] = acc;
        if (acc) begin
          e_addr[i]  = m_cnt[i];
          e_wdata[i] = ref_word(kind, imm);
        end
        if (start) begin
          m_run[i] = 1; m_done[i] = 0; m_full[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
        end else if (acc) begin
          if (ref_err(kind, imm)) m_err[i] = 1'b1;
          if (kind == 3'b100) begin
            m_run[i] = 0; m_done[i] = 1;
          end else if (m_cnt[i] == depth[i] - 1) begin
            m_run[i] = 0; m_full[i] = 1;
          end else begin
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_post(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic dn, input logic fl,
                            input logic er);
    string p;
    p = (i == 0) ? "big_" : "small_";
    chk({p, "imem_we"}, 32'(we), 32'(m_we[i]));
    chk({p, "done"}, 32'(dn), 32'(m_done[i]));
    chk({p, "full"}, 32'(fl), 32'(m_full[i]));
    chk({p, "err"}, 32'(er), 32'(m_err[i]));
    if (m_we[i] || m_show[i]) begin
      chk({p, "imem_addr"}, addr, 32'(e_addr[i]));
      chk({p, "imem_wdata"}, wdata, e_wdata[i]);
    end
  endtask

  // One clock: check in_ready before the edge, update model, check outputs after.
  task automatic tick();
    #1;
    chk("big_in_ready", 32'(b_ready), 32'(m_run[0] && !start));
    chk("small_in_ready", 32'(s_ready), 32'(m_run[1] && !start));
    @(posedge clk);
    model_edge();
    #1;
    check_post(0, b_we, 32'(b_addr), b_wdata, b_done, b_full, b_err);
    check_post(1, s_we, 32'(s_addr), s_wdata, s_done, s_full, s_err);
  endtask

  task automatic set_tuple(input logic [2:0] k, input int d, input int a, input int b,
                           input int f3, input int f7, input int iv);
    kind = k; rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = 21'(iv);
  endtask

  task automatic rand_tuple();
    int iv;
    case ($urandom_range(0, 3))
      0: iv = int'($urandom_range(0, 4095)) - 2048;
      1: iv = int'($urandom_range(0, 8191)) - 4096;
      2: iv = 2 * (int'($urandom_range(0, 4095)) - 2048);
      default: iv = int'($urandom);
    endcase
    set_tuple(($urandom_range(0, 15) == 0) ? 3'b100 : 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 127)), iv);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_tuple(3'b000, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single R-type word
    start = 1'b1; tick(); start = 1'b0;
    set_tuple(3'b011, 3, 1, 2, 0, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("rtype_word", b_wdata, 32'h002081B3);
    tick();

    // Load, store, halt back to back
    start = 1'b1; tick(); start = 1'b0; in_valid = 1'b1;
    set_tuple(3'b000, 5, 0, 0, 2, 0, 8); tick();
    chk("load_word", b_wdata, 32'h00802283);
    set_tuple(3'b010, 0, 0, 5, 2, 0, 12); tick();
    chk("store_word", b_wdata, 32'h00502623);
    set_tuple(3'b100, 9, 9, 9, 7, 99, 1234); tick();
    chk("halt_word", b_wdata, 32'h0000007F);
    chk("halt_done", 32'(b_done), 32'd1);
    set_tuple(3'b011, 1, 1, 1, 0, 0, 0); tick();
    in_valid = 1'b0; tick();

    // Branch encoding, then jal odd offset makes err sticky until start
    start = 1'b1; tick(); start = 1'b0; in_valid = 1'b1;
    set_tuple(3'b110, 0, 1, 2, 0, 0, -4); tick();
    chk("branch_word", b_wdata, 32'hFE208EE3);
    chk("branch_err", 32'(b_err), 32'd0);
    set_tuple(3'b111, 1, 0, 0, 0, 0, 3); tick();
    chk("jal_err", 32'(b_err), 32'd1);
    set_tuple(3'b001, 2, 3, 0, 0, 0, 5); tick();
    set_tuple(3'b110, 0, 1, 2, 0, 0, 4094); tick();
    set_tuple(3'b110, 0, 1, 2, 0, 0, -4096); tick();
    in_valid = 1'b0; tick();
    chk("err_sticky", 32'(b_err), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("err_cleared", 32'(b_err), 32'd0);

    // Small instance fills: four non-halt tuples, fifth refused
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      set_tuple(3'b011, n, n + 1, n + 2, 1, 32, 0); tick();
      if (n == 3) chk("small_full_4th", 32'(s_full), 32'd1);
    end
    in_valid = 1'b0; tick();
    // Halt as the fourth tuple: done rather than full
    start = 1'b1; tick(); start = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_tuple((n == 3) ? 3'b100 : 3'b001, n, n, 0, 0, 0, n); tick();
    end
    chk("small_done_last", 32'(s_done), 32'd1);
    chk("small_full_last", 32'(s_full), 32'd0);
    in_valid = 1'b0; tick();

    // Reset the cycle after an accept drops the pending write
    start = 1'b1; tick(); start = 1'b0; in_valid = 1'b1;
    set_tuple(3'b001, 4, 4, 0, 0, 0, 77); tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_we", 32'(b_we), 32'd0);
    // Start with in_valid held: no accept until the following cycle
    start = 1'b1; in_valid = 1'b1; set_tuple(3'b001, 6, 7, 0, 0, 0, -1); tick();
    start = 1'b0; tick();
    chk("restart_addr", 32'(b_addr), 32'd0);
    in_valid = 1'b0; tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 127) == 0);
      start    = ($urandom_range(0, 11) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rand_tuple();
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iencoder_loader.md
IENCODER_LOADER -- requirements
Module: iencoder_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (DEPTH = 2^ADDR_W).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a new load at word address 0.
REQ-005 SHALL have port in_valid, input, 1, meaning the field tuple is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a tuple this cycle.
REQ-007 SHALL have port kind, input, 3, meaning 000 load, 001 I-type, 011 R-type, 010 store, 110 branch, 111 jal, 101 jalr, 100 halt.
REQ-008 SHALL have ports rd, rs1 and rs2, input, 5 each, meaning the register indices.
REQ-009 SHALL have ports funct3 (input, 3) and funct7 (input, 7), meaning the ALU function fields.
REQ-010 SHALL have port imm, input, 21, meaning a signed byte immediate or offset.
REQ-011 SHALL have ports imem_we (output, 1), imem_addr (output, ADDR_W) and imem_wdata (output, 32), meaning the instruction-memory write port.
REQ-012 SHALL have port done, output, 1, meaning the halt word has been written.
REQ-013 SHALL have port full, output, 1, meaning the last address was written without a halt.
REQ-014 SHALL have port err, output, 1, meaning the sticky immediate range or alignment error.

Function
REQ-015 SHALL implement states IDLE, RUN, FULL and DONE; in_ready = (state==RUN) && !start.
REQ-016 Transitions SHALL be:
  - start: any state -> RUN, with address counter 0 and err cleared.
  - halt accepted in RUN -> DONE.
  - non-halt accepted at address DEPTH-1 -> FULL.
  - otherwise the state holds.
REQ-017 A tuple SHALL be accepted when in_valid && in_ready; throughput is 1 tuple per cycle.
REQ-018 An accepted tuple SHALL be written one cycle later: imem_we=1, imem_addr=counter value at acceptance, imem_wdata=encoded word; the counter increments by 1 per accept.
REQ-019 Encoding for the I-format kinds SHALL be:
  - load: opcode 0000011, bits[31:20]=imm[11:0], rs1, funct3, rd.
  - I-type: opcode 0010011, same fields as load.
  - jalr: opcode 1100111, same fields as load.
REQ-020 Encoding for R-type SHALL be opcode 0110011, {funct7, rs2, rs1, funct3, rd}.
REQ-021 Encoding for store SHALL be opcode 0100011, [31:25]=imm[11:5], [11:7]=imm[4:0], with rs2, rs1 and funct3.
REQ-022 Encoding for branch SHALL be opcode 1100011, [31:25]={imm[12],imm[10:5]}, [11:7]={imm[4:1],imm[11]}, with rs2, rs1 and funct3.
REQ-023 Encoding for jal SHALL be opcode 1101111, [31:12]={imm[20],imm[10:1],imm[11],imm[19:12]}, with rd.
REQ-024 Encoding for halt SHALL be 32'h0000007F, with all other fields ignored.
REQ-025 Fields unused by a format SHALL be ignored; out-of-range immediates SHALL be truncated, never saturated.
REQ-026 err SHALL set (sticky) on acceptance of any of the following:
  - I/S/jalr imm outside [-2048, 2047].
  - branch imm outside [-4096, 4094] or imm[0]=1.
  - jal imm[0]=1.
REQ-027 A halt accepted at address DEPTH-1 SHALL go to DONE, not FULL.
REQ-028 The counter SHALL never wrap; no accept occurs in FULL or DONE.
REQ-029 start in the same cycle as in_valid SHALL take priority: the tuple is not accepted, and the write of a tuple accepted the previous cycle still completes.
REQ-030 done=1 only in DONE and full=1 only in FULL, both registered and asserted the cycle imem_we writes the final word.
REQ-031 imem_we SHALL be 0 in every cycle not following an accept.

Reset
REQ-032 On rst: state=IDLE, counter=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, full=0, err=0, in_ready=0.
REQ-033 rst SHALL override start and in_valid; a write pending from the previous cycle is dropped, and imem_we=0 in the cycle after reset.

Verification
REQ-034 start, then R-type kind=011 rd=3 rs1=1 rs2=2 funct3=0 funct7=0 -> next cycle imem_we=1, addr=0, wdata=32'h002081B3.
REQ-035 Back-to-back load (rd=5, rs1=0, imm=8, funct3=2), store (rs1=0, rs2=5, imm=12, funct3=2), halt -> addrs 0,1,2, wdata 32'h00802283, 32'h00502623, 32'h0000007F; done=1 with the third write; in_ready=0 afterward.
REQ-036 Branch imm=-4 funct3=0 rs1=1 rs2=2 -> wdata 32'hFE208EE3, err=0; jal imm=3 -> err=1 and stays 1 until start.
REQ-037 ADDR_W=2, four non-halt tuples -> full=1 on the 4th write, in_ready=0, fifth tuple not written; a halt as the 4th tuple instead -> done=1, full=0.
REQ-038 rst asserted the cycle after an accept -> imem_we stays 0, all outputs at reset values; start with in_valid held high -> first write occurs one cycle later than the accept, at addr 0.
